// File: rtl/stack_pkg.sv
// Shared constants, command opcodes and sequencer states for the 8-entry LIFO controller.
package stack_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_PEEK  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/stack_ptr_8.sv
// Stack pointer for the 8-entry LIFO: 4-bit up/down counter that saturates at 0 and DEPTH.
module stack_ptr_8
  import stack_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + CW'(1);
    end else if (dec && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/stack_ctrl_8.sv
// Push/pop/peek/clear sequencer driving an external 8 x 16 register RAM as a LIFO.
// Optional feature: define STACK_PEEK_EN to make PEEK a non-destructive read of the top.
module stack_ctrl_8
  import stack_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] mem_in,
  output logic [AW-1:0]    mem_address,
  output logic             mem_load,
  input  logic [WIDTH-1:0] mem_out
);

  state_e state;
  op_e    op;
  op_e    op_q;
  logic   acc_err;
  logic   inc, dec, clr;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE);
  assign inc       = (state == ST_WRITE);
  // PEEK also passes through READ but must leave the pointer alone.
  assign dec       = (state == ST_READ) && (op_q == OP_POP);
  assign clr       = cmd_ready && cmd_valid && (op == OP_CLEAR);

  always_comb begin
    acc_err = 1'b0;
    case (op)
      OP_PUSH:  acc_err = full;
      OP_POP:   acc_err = empty;
`ifdef STACK_PEEK_EN
      OP_PEEK:  acc_err = empty;
`else
      OP_PEEK:  acc_err = 1'b1;
`endif
      default:  acc_err = 1'b0;
    endcase
  end

  stack_ptr_8 u_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .clr   (clr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= OP_PUSH;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      mem_load    <= 1'b0;
      mem_address <= '0;
      mem_in      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q <= op;
            if (acc_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= ST_RESP;
            end else begin
              case (op)
                OP_PUSH: begin
                  mem_address <= count[AW-1:0];
                  mem_in      <= cmd_data;
                  mem_load    <= 1'b1;
                  state       <= ST_WRITE;
                end
                OP_POP, OP_PEEK: begin
                  mem_address <= count[AW-1:0] - AW'(1);
                  state       <= ST_READ;
                end
                default: begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= '0;
                  state     <= ST_RESP;
                end
              endcase
            end
          end
        end
        ST_WRITE: begin
          mem_load  <= 1'b0;
          rsp_data  <= mem_in;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_READ: begin
          rsp_data  <= mem_out;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
